// File: rtl/grid_world_pkg.sv
// Shared cell codes, init FSM encoding and a constant-width helper for the grid world memory.
package grid_world_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_FOOD  = 2'b01;
  localparam logic [1:0] CELL_SNAKE = 2'b10;
  localparam logic [1:0] CELL_WALL  = 2'b11;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_SEED  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/grid_occ_counter.sv
// Tracks how many cells hold one particular code, from the old/new code of each committed write.
module grid_occ_counter
  import grid_world_pkg::*;
#(
  parameter int unsigned       CELL_W = 2,
  parameter int unsigned       CNT_W  = 8,
  parameter logic [CELL_W-1:0] CODE   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              wr,
  input  logic [CELL_W-1:0] old_code,
  input  logic [CELL_W-1:0] new_code,
  output logic [CNT_W-1:0]  cnt
);

  // Same code in and out nets to zero, so no special case is needed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (wr) begin
      cnt <= cnt + CNT_W'(new_code == CODE) - CNT_W'(old_code == CODE);
    end
  end

endmodule

// File: rtl/grid_world_mem.sv
// Game-world cell memory: self-clearing/seeding init, registered read port, bounded write port, occupancy counts.
module grid_world_mem
  import grid_world_pkg::*;
#(
  parameter int unsigned GRID_W = 15,
  parameter int unsigned GRID_H = 15,
  parameter int unsigned CELL_W = 2,
  parameter int unsigned XY_W   = 5,
  parameter int unsigned FOOD_X = 1,
  parameter int unsigned FOOD_Y = 4,
  localparam int unsigned CNT_W = clog2(GRID_W * GRID_H + 1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              wr_en,
  input  logic [XY_W-1:0]   wr_x,
  input  logic [XY_W-1:0]   wr_y,
  input  logic [CELL_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [XY_W-1:0]   rd_x,
  input  logic [XY_W-1:0]   rd_y,
  output logic              rd_valid,
  output logic [CELL_W-1:0] rd_data,
  output logic              rd_err,
  output logic [CNT_W-1:0]  food_cnt,
  output logic [CNT_W-1:0]  snake_cnt
);

  localparam int unsigned      CELLS     = GRID_W * GRID_H;
  localparam int unsigned      ADDR_W    = clog2(CELLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] FOOD_ADDR = ADDR_W'(GRID_W * (FOOD_Y - 1) + (FOOD_X - 1));

  logic [CELL_W-1:0] mem [CELLS];

  logic [1:0]        state, state_next;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_in_range, rd_in_range;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              wr_acc, wr_fire, rd_fire;
  logic [CELL_W-1:0] wr_old;

  assign wr_in_range = (wr_x != '0) && (32'(wr_x) <= GRID_W) && (wr_y != '0) && (32'(wr_y) <= GRID_H);
  assign rd_in_range = (rd_x != '0) && (32'(rd_x) <= GRID_W) && (rd_y != '0) && (32'(rd_y) <= GRID_H);
  assign wr_addr = ADDR_W'(GRID_W * (32'(wr_y) - 32'd1) + 32'(wr_x) - 32'd1);
  assign rd_addr = ADDR_W'(GRID_W * (32'(rd_y) - 32'd1) + 32'(rd_x) - 32'd1);

  // ready is high exactly while in RUN, so it doubles as the port-accept qualifier.
  assign wr_acc  = ready && wr_en;
  assign wr_fire = wr_acc && wr_in_range;
  assign rd_fire = ready && rd_req;
  assign wr_old  = mem[wr_addr];

  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_addr == LAST_ADDR) state_next = ST_SEED;
      ST_SEED:  state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
      wr_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
      ready    <= (state_next == ST_RUN);
      rd_valid <= rd_fire;
      rd_err   <= rd_fire && !rd_in_range;
      rd_data  <= (rd_fire && rd_in_range) ? mem[rd_addr] : '0;
      wr_err   <= wr_acc && !wr_in_range;
    end
  end

  // Storage has no reset; the CLEAR sweep initialises it after every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      case (state)
        ST_CLEAR: mem[clr_addr] <= CELL_W'(CELL_EMPTY);
        ST_SEED: begin
          mem[ADDR_W'(0)] <= CELL_W'(CELL_SNAKE);
          mem[ADDR_W'(1)] <= CELL_W'(CELL_SNAKE);
          mem[ADDR_W'(2)] <= CELL_W'(CELL_SNAKE);
          mem[FOOD_ADDR]  <= CELL_W'(CELL_FOOD);
        end
        ST_RUN: if (wr_fire) mem[wr_addr] <= wr_data;
        default: ;
      endcase
    end
  end

  grid_occ_counter #(.CELL_W(CELL_W), .CNT_W(CNT_W), .CODE(CELL_W'(CELL_FOOD))) u_food_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_SEED),
    .load_val (CNT_W'(1)),
    .wr       (wr_fire),
    .old_code (wr_old),
    .new_code (wr_data),
    .cnt      (food_cnt)
  );

  grid_occ_counter #(.CELL_W(CELL_W), .CNT_W(CNT_W), .CODE(CELL_W'(CELL_SNAKE))) u_snake_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_SEED),
    .load_val (CNT_W'(3)),
    .wr       (wr_fire),
    .old_code (wr_old),
    .new_code (wr_data),
    .cnt      (snake_cnt)
  );

endmodule

// File: tb/tb_grid_world_mem.sv
// Scoreboard bench for grid_world_mem: directed reads/writes, bounds, counters, init latency and resets.
module tb_grid_world_mem;
  import grid_world_pkg::*;

  localparam int unsigned XY_W   = 5;
  localparam int unsigned CELL_W = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int          INIT_CYCLES = 226;

  logic              clk;
  logic              rst;
  logic              ready;
  logic              wr_en;
  logic [XY_W-1:0]   wr_x, wr_y;
  logic [CELL_W-1:0] wr_data;
  logic              wr_err;
  logic              rd_req;
  logic [XY_W-1:0]   rd_x, rd_y;
  logic              rd_valid;
  logic [CELL_W-1:0] rd_data;
  logic              rd_err;
  logic [CNT_W-1:0]  food_cnt, snake_cnt;

  grid_world_mem dut (
    .clk       (clk),
    .rst       (rst),
    .ready     (ready),
    .wr_en     (wr_en),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .rd_req    (rd_req),
    .rd_x      (rd_x),
    .rd_y      (rd_y),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .food_cnt  (food_cnt),
    .snake_cnt (snake_cnt)
  );

  typedef struct {
    logic [CELL_W-1:0] data;
    logic              err;
    string             name;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_init;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented read result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_rd_valid", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        check({mon_e.name, "_data"}, int'(rd_data), int'(mon_e.data));
        check({mon_e.name, "_err"}, int'(rd_err), int'(mon_e.err));
      end
    end else begin
      check("idle_rd_data_err_zero", int'({rd_err, rd_data}), 0);
    end
  end

  task automatic do_read(input int x, input int y, input logic [1:0] d, input logic err, input string nm);
    exp_t e;
    rd_req = 1'b1;
    rd_x   = XY_W'(x);
    rd_y   = XY_W'(y);
    e.data = d;
    e.err  = err;
    e.name = nm;
    expq.push_back(e);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic do_write(input int x, input int y, input logic [1:0] d);
    wr_en   = 1'b1;
    wr_x    = XY_W'(x);
    wr_y    = XY_W'(y);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Counts posedges from the first one with rst=1 until ready is seen; bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (ready) break;
    end
  endtask

  task automatic check_counts(input string nm, input int f, input int s);
    check({nm, "_food_cnt"}, int'(food_cnt), f);
    check({nm, "_snake_cnt"}, int'(snake_cnt), s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    wr_x = '0; wr_y = '0; wr_data = '0; rd_x = '0; rd_y = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_wr_err", int'(wr_err), 0);
    check_counts("rst", 0, 0);
    rst = 1'b1;
    wait_ready(n_init);
    check("init_latency", n_init, INIT_CYCLES);
    @(negedge clk);
    check_counts("seed", 1, 3);

    // Seeded contents, back-to-back reads
    do_read(1, 1, CELL_SNAKE, 1'b0, "seed_1_1");
    do_read(2, 1, CELL_SNAKE, 1'b0, "seed_2_1");
    do_read(3, 1, CELL_SNAKE, 1'b0, "seed_3_1");
    do_read(4, 1, CELL_EMPTY, 1'b0, "seed_4_1");
    do_read(1, 4, CELL_FOOD,  1'b0, "seed_1_4");
    do_read(15, 1, CELL_EMPTY, 1'b0, "corner_15_1");

    // Overwrite counting
    do_write(1, 4, CELL_SNAKE);
    check_counts("ovr1", 0, 4);
    check("ovr1_wr_err", int'(wr_err), 0);
    do_write(1, 4, CELL_SNAKE);
    check_counts("ovr2", 0, 4);
    do_read(1, 4, CELL_SNAKE, 1'b0, "ovr_1_4");

    do_write(15, 15, CELL_FOOD);
    check_counts("w15", 1, 4);
    do_read(15, 15, CELL_FOOD, 1'b0, "rd_15_15");

    // Bounds
    do_read(0, 5, 2'b00, 1'b1, "oor_0_5");
    do_read(15, 16, 2'b00, 1'b1, "oor_15_16");
    do_write(16, 1, CELL_SNAKE);
    check("oor_w16_wr_err", int'(wr_err), 1);
    check_counts("oor_w16", 1, 4);
    @(negedge clk);
    check("oor_w16_wr_err_drop", int'(wr_err), 0);
    do_write(1, 0, CELL_FOOD);
    check("oor_w1_0_wr_err", int'(wr_err), 1);
    check_counts("oor_w1_0", 1, 4);

    // Same-address read and write in one cycle: old data returned
    rd_req = 1'b1; rd_x = 5'd2; rd_y = 5'd2;
    wr_en = 1'b1; wr_x = 5'd2; wr_y = 5'd2; wr_data = CELL_WALL;
    begin
      exp_t e;
      e.data = CELL_EMPTY; e.err = 1'b0; e.name = "rbw_old";
      expq.push_back(e);
    end
    @(negedge clk);
    rd_req = 1'b0; wr_en = 1'b0;
    do_read(2, 2, CELL_WALL, 1'b0, "rbw_new");
    check_counts("wall", 1, 4);
    do_write(1, 1, CELL_EMPTY);
    check_counts("snake_dec", 1, 3);

    // Reset during RUN with a read accepted on the same edge
    rst = 1'b0; rd_req = 1'b1; rd_x = 5'd1; rd_y = 5'd1;
    @(negedge clk);
    rst = 1'b1; rd_req = 1'b0;
    check("run_rst_ready", int'(ready), 0);
    check("run_rst_rd_valid", int'(rd_valid), 0);
    check_counts("run_rst", 0, 0);
    wait_ready(n_init);
    check("run_rst_init_latency", n_init, INIT_CYCLES);
    @(negedge clk);
    check_counts("reinit", 1, 3);
    do_read(15, 15, CELL_EMPTY, 1'b0, "reinit_15_15");
    do_read(2, 2, CELL_EMPTY, 1'b0, "reinit_2_2");
    do_read(1, 1, CELL_SNAKE, 1'b0, "reinit_1_1");
    do_read(1, 4, CELL_FOOD, 1'b0, "reinit_1_4");

    // Reset during CLEAR at clr_addr=100; port requests meanwhile must be ignored
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rd_req = 1'b1; rd_x = 5'd1; rd_y = 5'd1;
    wr_en = 1'b1; wr_x = 5'd16; wr_y = 5'd1; wr_data = CELL_SNAKE;
    repeat (100) @(negedge clk);
    check("clear_wr_err_ignored", int'(wr_err), 0);
    check("clear_ready", int'(ready), 0);
    rst = 1'b0; rd_req = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    check("clr_rst_ready", int'(ready), 0);
    check("clr_rst_rd_valid", int'(rd_valid), 0);
    rst = 1'b1;
    wait_ready(n_init);
    check("clr_rst_init_latency", n_init, INIT_CYCLES);
    @(negedge clk);
    check_counts("reinit2", 1, 3);
    do_read(1, 1, CELL_SNAKE, 1'b0, "reinit2_1_1");

    repeat (3) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
